pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 114 +++++++++++
 tb/tb_pipe_stage_skid.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline register stage with optional two-entry skid buffer
// Flush and reset empty the stage; control bits are masked to zero on bubbles.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  logic              main_valid;
  logic              main_valid_n;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] main_ctrl_n;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] main_data_n;
  logic              skid_valid;
  logic              skid_valid_n;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [1:0]        occ_q;
  logic              in_xfer;
  logic              out_xfer;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign occupancy = occ_q;
  assign out_xfer  = main_valid && out_ready;
  assign in_xfer   = in_valid && in_ready && !flush && !rst;

  // Skid entries only ever wait behind main, so main is refilled from skid first.
  always_comb begin
    main_valid_n = main_valid;
    main_ctrl_n  = main_ctrl;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (out_xfer) begin
      if (skid_valid) begin
        main_ctrl_n  = skid_ctrl;
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
      end else if (in_xfer) begin
        main_ctrl_n = in_ctrl;
        main_data_n = in_data;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_valid) begin
        main_valid_n = 1'b1;
        main_ctrl_n  = in_ctrl;
        main_data_n  = in_data;
      end else begin
        skid_valid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      occ_q      <= 2'd0;
    end else begin
      main_valid <= main_valid_n;
      main_ctrl  <= main_ctrl_n;
      main_data  <= main_data_n;
      occ_q      <= {1'b0, main_valid_n} + {1'b0, skid_valid_n};
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: depends only on the skid flop, never on out_ready.
      assign in_ready = !skid_valid && !rst;

      always_ff @(posedge clk) begin
        if (rst) begin
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
          skid_data  <= '0;
        end else begin
          skid_valid <= skid_valid_n;
          if (skid_valid_n && !skid_valid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end
        end
      end
    end else begin : g_no_skid
      assign in_ready   = (out_ready || !main_valid) && !rst;
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid in both SKID modes
// Index 0 is the SKID=0 instance, index 1 the SKID=1 instance; both see the same stimulus.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;

  logic [1:0]  ir_v;
  logic [1:0]  ov_v;
  logic [7:0]  ctrl_v [2];
  logic [31:0] data_v [2];
  logic [1:0]  occ_v  [2];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        checking = 1'b0;

  // Reference: each stage is an ordered list of held entries {ctrl, data}.
  logic [39:0] mq [2][2];
  int          mcnt [2];
  logic [31:0] last_data [2];

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir_v[0]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov_v[0]), .out_ready(out_ready), .out_ctrl(ctrl_v[0]), .out_data(data_v[0]),
    .flush(flush), .occupancy(occ_v[0])
  );

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir_v[1]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov_v[1]), .out_ready(out_ready), .out_ctrl(ctrl_v[1]), .out_data(data_v[1]),
    .flush(flush), .occupancy(occ_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int m, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [SKID=%0d] t=%0t actual=%0h expected=%0h", nm, m, $time, act, exp);
    end
  endtask

  function automatic logic model_ready(input int m);
    if (rst) return 1'b0;
    if (m == 1) return mcnt[1] < 2;
    return (mcnt[0] == 0) || out_ready;
  endfunction

  initial begin
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0;
      last_data[m] = '0;
    end
  end

  // Stimulus side of the scoreboard: accepted inputs are queued, consumed heads removed.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic rdy;
      logic vld;
      rdy = model_ready(m);
      vld = mcnt[m] > 0;
      if (rst) begin
        mcnt[m] = 0;
        last_data[m] = '0;
      end else if (flush) begin
        mcnt[m] = 0;
      end else begin
        if (vld && out_ready) begin
          mq[m][0] = mq[m][1];
          mcnt[m]  = mcnt[m] - 1;
        end
        if (in_valid && rdy) begin
          mq[m][mcnt[m]] = {in_ctrl, in_data};
          mcnt[m] = mcnt[m] + 1;
        end
      end
      if (mcnt[m] > 0) last_data[m] = mq[m][0][31:0];
    end
  end

  // Monitor: compare whatever each stage presents against the head of its queue.
  always @(negedge clk) begin
    if (checking) begin
      for (int m = 0; m < 2; m++) begin
        chk("out_valid", m, 64'(ov_v[m]), 64'(mcnt[m] > 0));
        chk("occupancy", m, 64'(occ_v[m]), 64'(mcnt[m]));
        chk("in_ready", m, 64'(ir_v[m]), 64'(model_ready(m)));
        if (mcnt[m] > 0) begin
          chk("out_data", m, 64'(data_v[m]), 64'(mq[m][0][31:0]));
          chk("out_ctrl", m, 64'(ctrl_v[m]), 64'(mq[m][0][39:32]));
        end else begin
          chk("hold_data", m, 64'(data_v[m]), 64'(last_data[m]));
          chk("bubble_ctrl", m, 64'(ctrl_v[m]), 64'd0);
        end
      end
    end
  end

  task automatic set(input logic iv, input logic [31:0] d, input logic orr, input logic fl, input logic r);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = d[7:0] ^ 8'h3C;
    out_ready = orr;
    flush     = fl;
    rst       = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic iv, input logic [31:0] d, input logic orr, input logic fl, input logic r);
    set(iv, d, orr, fl, r);
    step();
  endtask

  initial begin
    logic [31:0] vals [3];
    vals[0] = 32'h11;
    vals[1] = 32'h22;
    vals[2] = 32'h33;

    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    checking = 1'b1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_occ", m, 64'(occ_v[m]), 64'd0);
      chk("rst_in_ready", m, 64'(ir_v[m]), 64'd0);
      chk("rst_data", m, 64'(data_v[m]), 64'd0);
    end

    // Streaming at full rate: one-cycle latency, occupancy steady at 1.
    for (int i = 0; i < 3; i++) begin
      cyc(1, vals[i], 1, 0, 0);
      for (int m = 0; m < 2; m++) begin
        chk("stream_data", m, 64'(data_v[m]), 64'(vals[i]));
        chk("stream_occ", m, 64'(occ_v[m]), 64'd1);
      end
    end
    cyc(0, 0, 1, 0, 0);

    // Skid fill and drain.
    cyc(1, 32'hA1, 0, 0, 0);
    cyc(1, 32'hA2, 0, 0, 0);
    chk("skid_fill_occ", 1, 64'(occ_v[1]), 64'd2);
    chk("skid_fill_rdy", 1, 64'(ir_v[1]), 64'd0);
    chk("noskid_occ", 0, 64'(occ_v[0]), 64'd1);
    cyc(1, 32'hA3, 0, 0, 0);
    chk("skid_hold_data", 1, 64'(data_v[1]), 64'hA1);
    cyc(1, 32'hA3, 1, 0, 0);
    chk("skid_drain1", 1, 64'(data_v[1]), 64'hA2);
    chk("skid_drain_occ", 1, 64'(occ_v[1]), 64'd1);
    chk("skid_drain_rdy", 1, 64'(ir_v[1]), 64'd1);
    cyc(1, 32'hA3, 1, 0, 0);
    chk("skid_drain2", 1, 64'(data_v[1]), 64'hA3);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Flush with two held entries and a coincident offer.
    cyc(1, 32'hB1, 0, 0, 0);
    cyc(1, 32'hB2, 0, 0, 0);
    cyc(1, 32'hFF, 0, 1, 0);
    for (int m = 0; m < 2; m++) begin
      chk("flush_valid", m, 64'(ov_v[m]), 64'd0);
      chk("flush_ctrl", m, 64'(ctrl_v[m]), 64'd0);
      chk("flush_occ", m, 64'(occ_v[m]), 64'd0);
      chk("flush_rdy", m, 64'(ir_v[m]), 64'd1);
    end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Reset while full.
    cyc(1, 32'hC1, 0, 0, 0);
    cyc(1, 32'hC2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    set(0, 0, 0, 0, 0);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rel_rdy", m, 64'(ir_v[m]), 64'd1);
      chk("rel_valid", m, 64'(ov_v[m]), 64'd0);
      chk("rel_data", m, 64'(data_v[m]), 64'd0);
    end
    step();

    // Single-entry backpressure.
    cyc(1, 32'h55, 1, 0, 0);
    set(0, 0, 0, 0, 0);
    #1;
    chk("bp_rdy_low", 0, 64'(ir_v[0]), 64'd0);
    step();
    set(1, 32'h66, 1, 0, 0);
    #1;
    chk("bp_rdy_high", 0, 64'(ir_v[0]), 64'd1);
    step();
    for (int m = 0; m < 2; m++) chk("bp_next", m, 64'(data_v[m]), 64'h66);
    cyc(0, 0, 1, 0, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      set($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
          $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
      in_ctrl = 8'($urandom);
      step();
    end

    cyc(0, 0, 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
